reg_stage_rev_m: RTL
====================

Name: reg_stage_rev_m

Overview:
Fully registered skid-buffer stage for valid/ready handshake interfaces. It breaks the combinational ready path (ready_dst -> ready_src) as well as the forward valid/data path. The block sits between a source and a sink wherever timing closure on a backpressure path fails. It is the companion of the forward-only register stage: same port set and same DATA_T convention, with ready_src driven straight from a flop.

Parameters:
DATA_T, logic [31:0], payload type; any packed type (packed struct or packed array); width W = $bits(DATA_T).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
valid_src  input  1  source presents a beat
ready_src  output  1  stage can accept; driven directly by a flop
src  input  W  source payload (DATA_T)
valid_dst  output  1  dst holds a valid beat; driven directly by a flop
ready_dst  input  1  sink accepts
dst  output  W  payload to sink; driven directly by the main register
count  output  2  occupancy, 0..2; driven by a flop

Behaviour:
- Handshakes: in_hs = valid_src && ready_src; out_hs = valid_dst && ready_dst.
- Storage: main register M drives dst. Skid register S holds the beat that was accepted while the sink stalled.
- State is EMPTY (0), ONE (1) or TWO (2). count equals the state encoding.
- valid_dst = (state != EMPTY), registered.
- ready_src is registered with next value = (next_state != TWO).
- Reset (rst=1 at an edge):
  - state <= EMPTY, count <= 0, valid_dst <= 0, ready_src <= 0.
  - M and S are not reset; dst is unspecified while valid_dst=0.
- First edge with rst=0: ready_src <= 1. No beat can be accepted before then.
- Transitions:
  - EMPTY, in_hs: M <= src, go to ONE.
  - ONE, in_hs && !out_hs: S <= src, go to TWO.
  - ONE, in_hs && out_hs: M <= src, stay in ONE (full-throughput streaming).
  - ONE, !in_hs && out_hs: go to EMPTY.
  - TWO, out_hs: M <= S, go to ONE. in_hs cannot occur here because ready_src=0.
  - Any other combination: hold state and registers.
- Latency: a beat accepted at edge N appears on dst with valid_dst=1 after edge N; minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained while ready_dst=1.
- Ordering: beats leave in acceptance order. No beat is lost, duplicated or reordered.
- Backpressure: when ready_dst drops, at most one additional beat is absorbed into S. ready_src falls one cycle after ready_dst falls and rises one cycle after the TWO -> ONE transition.
- AXI-style rule: valid_dst, once asserted, stays high and dst stays stable until out_hs.
- valid_src toggling with ready_src=0 has no effect.
- Reset mid-operation: all held beats are discarded. valid_dst=0 and ready_src=0 after the reset edge, and normal operation resumes as from power-up.
- Combinational paths from any input to any output: none.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, release -> valid_dst=0, count=0 throughout; ready_src=0 during reset and =1 from the first post-reset edge.
- Streaming: ready_dst=1, send 0x00..0x0F back-to-back -> dst carries 0x00..0x0F in order, one per cycle, 1-cycle latency, ready_src stays 1, count stays 1 in steady state.
- Stall absorb: stream 0xA0, 0xA1, 0xA2, drop ready_dst for 5 cycles after 0xA0 is presented:
  - count reaches 2 and ready_src=0.
  - dst holds 0xA0 stable for the full 5 cycles.
  - After ready_dst=1, the sink sees 0xA0, 0xA1, 0xA2 in order with no loss.
- Random: random valid_src and ready_dst (50% each), 1000 beats with an incrementing payload -> scoreboard matches exactly; no output ever changes in the same cycle as its input (register-only check).
- Reset mid-operation: with count=2 (0xB0 and 0xB1 held), assert rst for 1 cycle -> valid_dst=0 and count=0 next cycle; sending 0xC0 afterwards delivers only 0xC0.
- Drain: fill to count=2, then ready_dst=1 with valid_src=0 -> count goes 2, 1, 0 over consecutive edges; valid_dst=0 after the last beat.

Source files
------------

// File: rtl/reg_stage_rev_m.sv
// Fully registered skid-buffer stage: breaks both the forward valid/data path
// and the backward ready path of a valid/ready handshake.
module reg_stage_rev_m #(
    parameter type DATA_T = logic [31:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_src,
    output logic       ready_src,
    input  DATA_T      src,
    output logic       valid_dst,
    input  logic       ready_dst,
    output DATA_T      dst,
    output logic [1:0] count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   ready_src_r;
    logic   valid_dst_r;
    logic [1:0] count_r;
    DATA_T  main_r;
    DATA_T  skid_r;

    logic in_hs_s;
    logic out_hs_s;
    logic load_main_src_s;
    logic load_main_skid_s;
    logic load_skid_s;

    assign in_hs_s  = valid_src && ready_src_r;
    assign out_hs_s = valid_dst_r && ready_dst;

    // Next-state and register-load decode for the three occupancy states.
    always_comb begin
        state_s          = state_r;
        load_main_src_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_hs_s) begin
                    load_main_src_s = 1'b1;
                    state_s         = ST_ONE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_hs_s && out_hs_s) begin
                    load_main_src_s = 1'b1;
                    state_s         = ST_ONE;
                end else if (in_hs_s) begin
                    load_skid_s = 1'b1;
                    state_s     = ST_TWO;
                end else if (out_hs_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // ready_src is low in this state, so only the drain of M matters.
                if (out_hs_s) begin
                    load_main_skid_s = 1'b1;
                    state_s          = ST_ONE;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Control flops: every handshake output is taken from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            count_r     <= 2'd0;
            valid_dst_r <= 1'b0;
            ready_src_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= state_s;
            valid_dst_r <= (state_s != ST_EMPTY);
            ready_src_r <= (state_s != ST_TWO);
        end
    end

    // Payload storage; contents are don't-care while the stage is empty.
    always_ff @(posedge clk) begin
        if (load_main_src_s) begin
            main_r <= src;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
        if (load_skid_s) begin
            skid_r <= src;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign ready_src = ready_src_r;
    assign valid_dst = valid_dst_r;
    assign dst       = main_r;
    assign count     = count_r;

endmodule
